// File: rtl/round_ctrl.sv
// round_ctrl: per-round controller for the tug-of-war scorer.
// Synchronises both pushbuttons, waits a pseudo-random delay before lighting
// the LEDs, reports the first push (including jump-the-light pushes) as a
// one-cycle result, re-arms once both buttons are released and freezes once
// the game is over.
module round_ctrl #(
    parameter int CNT_W         = 16,
    parameter int MIN_DELAY     = 1000,
    parameter int RAND_BITS     = 12,
    parameter int LIGHT_TIMEOUT = 40000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic pbl,
    input  logic pbr,
    input  logic game_over,
    output logic leds_on,
    output logic winrnd,
    output logic right,
    output logic tie
);

    // Round states.
    localparam logic [2:0] ST_RELEASE = 3'd0;
    localparam logic [2:0] ST_DELAY   = 3'd1;
    localparam logic [2:0] ST_LIGHT   = 3'd2;
    localparam logic [2:0] ST_RESULT  = 3'd3;
    localparam logic [2:0] ST_OVER    = 3'd4;

    // Counter constants. MIN_DELAY + (2^RAND_BITS - 1) must fit in CNT_W bits;
    // the default set tops out at 5095, well inside 16 bits.
    localparam logic [CNT_W-1:0] MIN_DELAY_C = CNT_W'(MIN_DELAY);
    localparam logic [CNT_W-1:0] LIGHT_C     = CNT_W'(LIGHT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Mask selecting the low RAND_BITS of the LFSR. Built as a mask rather than
    // a part-select so RAND_BITS = 0 (fixed delay) stays legal.
    localparam logic [15:0] RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);

    // Synchroniser and edge-detect flops.
    logic pbl_meta, sl, sl_d;
    logic pbr_meta, sr, sr_d;
    logic push_l, push_r, push_any;

    // Pseudo-random source.
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [CNT_W-1:0] rand_add;

    // FSM state, down-counter and their next values.
    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             leds_nx, winrnd_nx, right_nx, tie_nx;

    // Two-flop synchronisers plus one delay flop per button for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pbl_meta <= 1'b0;
            sl       <= 1'b0;
            sl_d     <= 1'b0;
            pbr_meta <= 1'b0;
            sr       <= 1'b0;
            sr_d     <= 1'b0;
        end else begin
            pbl_meta <= pbl;
            sl       <= pbl_meta;
            sl_d     <= sl;
            pbr_meta <= pbr;
            sr       <= pbr_meta;
            sr_d     <= sr;
        end
    end

    // Rising edges of the synchronised buttons; a held button gives one pulse.
    assign push_l   = sl & ~sl_d;
    assign push_r   = sr & ~sr_d;
    assign push_any = push_l | push_r;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11; free-running every cycle.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign rand_add = CNT_W'(lfsr & RAND_MASK);

    // Next-state, counter and output decode for the round FSM.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        leds_nx   = leds_on;
        winrnd_nx = 1'b0;
        right_nx  = 1'b0;
        tie_nx    = 1'b0;
        case (state)
            ST_RELEASE: begin
                // Lights off, pushes ignored until both buttons are up.
                leds_nx = 1'b0;
                if (game_over) begin
                    state_nx = ST_OVER;
                end else if (!sl && !sr) begin
                    cnt_nx   = MIN_DELAY_C + rand_add;
                    state_nx = ST_DELAY;
                end
            end
            ST_DELAY: begin
                // A push here is a jump-the-light; it beats counter expiry.
                leds_nx = 1'b0;
                if (push_any) begin
                    winrnd_nx = 1'b1;
                    right_nx  = push_r & ~push_l;
                    tie_nx    = push_l & push_r;
                    state_nx  = ST_RESULT;
                end else if (cnt == '0) begin
                    leds_nx  = 1'b1;
                    cnt_nx   = LIGHT_C;
                    state_nx = ST_LIGHT;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            ST_LIGHT: begin
                // Lights on; first push wins, otherwise the round is abandoned.
                leds_nx = 1'b1;
                if (push_any) begin
                    winrnd_nx = 1'b1;
                    right_nx  = push_r & ~push_l;
                    tie_nx    = push_l & push_r;
                    state_nx  = ST_RESULT;
                end else if (cnt == '0) begin
                    leds_nx  = 1'b0;
                    state_nx = ST_RELEASE;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            ST_RESULT: begin
                // Result pulse is on the outputs this cycle; clear and re-arm.
                leds_nx  = 1'b0;
                state_nx = ST_RELEASE;
            end
            ST_OVER: begin
                // Frozen until reset.
                leds_nx = 1'b0;
            end
            default: begin
                leds_nx  = 1'b0;
                state_nx = ST_RELEASE;
            end
        endcase
    end

    // Register FSM state, counter and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RELEASE;
            cnt     <= '0;
            leds_on <= 1'b0;
            winrnd  <= 1'b0;
            right   <= 1'b0;
            tie     <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            leds_on <= leds_nx;
            winrnd  <= winrnd_nx;
            right   <= right_nx;
            tie     <= tie_nx;
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl: directed bench for round_ctrl with a short fixed delay
// (MIN_DELAY=10, RAND_BITS=0) and a short light window (LIGHT_TIMEOUT=20).
module tb_round_ctrl;

    localparam int CNT_W         = 16;
    localparam int MIN_DELAY     = 10;
    localparam int RAND_BITS     = 0;
    localparam int LIGHT_TIMEOUT = 20;

    // Edge 1 after arming leaves RELEASE, LEDs light MIN_DELAY+1 edges later.
    localparam int ARM_TO_LIGHT  = 1 + MIN_DELAY + 1;
    // LIGHT holds the loaded value plus the cycle that sees zero.
    localparam int LIGHT_CYCLES  = LIGHT_TIMEOUT + 1;
    // Pin sampled at edge n, push after n+1, result registered at n+2.
    localparam int PUSH_LATENCY  = 3;

    logic clk, rst, pbl, pbr, game_over;
    logic leds_on, winrnd, right, tie;

    int n_cmp = 0;
    int n_err = 0;

    // Expected result records {right, tie, leds_on}, one per winrnd pulse.
    logic [2:0] exp_q[$];

    typedef struct {
        logic pl;
        logic pr;
        logic in_light;
        logic exp_right;
        logic exp_tie;
        logic exp_leds;
        int   hold;
    } row_t;

    row_t rows[6];

    round_ctrl #(
        .CNT_W(CNT_W),
        .MIN_DELAY(MIN_DELAY),
        .RAND_BITS(RAND_BITS),
        .LIGHT_TIMEOUT(LIGHT_TIMEOUT),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pbl(pbl),
        .pbr(pbr),
        .game_over(game_over),
        .leds_on(leds_on),
        .winrnd(winrnd),
        .right(right),
        .tie(tie)
    );

    // Clock: 10 ns period, posedge active; everything is sampled on negedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every winrnd pulse must match the oldest expected record.
    always @(negedge clk) begin
        if (rst === 1'b0 && winrnd !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_winrnd: got winrnd=%b expected 0 at %0t", winrnd, $time);
            end else begin
                check("result_fields", {29'd0, right, tie, leds_on}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    // Count negedges until leds_on equals val; expiry is a failure.
    task automatic wait_level(input logic val, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (leds_on !== val && n < budget);
        if (leds_on !== val) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_leds_timeout: got %b expected %b", leds_on, val);
        end
    endtask

    // Count negedges until winrnd; optionally require the LEDs to stay dark.
    task automatic wait_winrnd(input int budget, input logic chk_dark, output int lat);
        logic found;
        found = 1'b0;
        lat = 0;
        while (!found && lat < budget) begin
            @(negedge clk);
            lat++;
            if (winrnd === 1'b1) found = 1'b1;
            if (chk_dark) check("dark_before_result", {31'd0, leds_on}, 32'd0);
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_winrnd_timeout: got no winrnd expected one within %0d", budget);
        end
    endtask

    initial begin
        int n;
        int lat;
        int lit;

        //                 pl    pr    light exp_r exp_t exp_l hold
        rows[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 40};
        rows[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        rows[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        rows[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
        rows[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        rows[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};

        // Reset with buttons low.
        rst = 1'b1;
        pbl = 1'b0;
        pbr = 1'b0;
        game_over = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_leds", {31'd0, leds_on}, 32'd0);
        check("reset_winrnd", {31'd0, winrnd}, 32'd0);
        check("reset_right", {31'd0, right}, 32'd0);
        check("reset_tie", {31'd0, tie}, 32'd0);
        rst = 1'b0;

        // First round: LEDs light a fixed number of edges after release.
        wait_level(1'b1, 100, n);
        check("arm_to_light", n, ARM_TO_LIGHT);

        // Table of round results.
        for (int r = 0; r < 6; r++) begin
            if (rows[r].in_light) begin
                if (leds_on !== 1'b1) wait_level(1'b1, 200, n);
            end else begin
                repeat (3) @(negedge clk);
            end
            exp_q.push_back({rows[r].exp_right, rows[r].exp_tie, rows[r].exp_leds});
            pbl = rows[r].pl;
            pbr = rows[r].pr;
            wait_winrnd(12, !rows[r].in_light, lat);
            check($sformatf("latency_row%0d", r), lat, PUSH_LATENCY);
            @(negedge clk);
            check($sformatf("cleared_row%0d", r), {28'd0, winrnd, right, tie, leds_on}, 32'd0);
            if (rows[r].hold > 0) begin
                repeat (rows[r].hold) @(negedge clk);
                check($sformatf("held_stays_dark_row%0d", r), {31'd0, leds_on}, 32'd0);
            end
            pbl = 1'b0;
            pbr = 1'b0;
        end

        // Timeout: no push, LIGHT expires, a new DELAY follows.
        wait_level(1'b1, 200, n);
        wait_level(1'b0, 100, n);
        check("light_timeout_len", n, LIGHT_CYCLES);
        wait_level(1'b1, 100, n);
        check("rearm_after_timeout", n, ARM_TO_LIGHT);

        // Game over: one result, then the scorer raises game_over.
        exp_q.push_back(3'b001);
        pbl = 1'b1;
        wait_winrnd(12, 1'b0, lat);
        check("latency_before_over", lat, PUSH_LATENCY);
        game_over = 1'b1;
        lit = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (leds_on === 1'b1) lit++;
            pbl = ((i % 16) < 8);
            pbr = ((i % 10) < 3);
            if (i == 500) game_over = 1'b0;
        end
        check("over_no_leds", lit, 0);
        pbl = 1'b0;
        pbr = 1'b0;
        repeat (3) @(negedge clk);
        check("over_still_dark", {31'd0, leds_on}, 32'd0);

        // Only reset leaves the frozen state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_level(1'b1, 100, n);
        check("arm_after_reset", n, ARM_TO_LIGHT);

        // Reset mid-LIGHT drops the LEDs without a clock edge.
        #1 rst = 1'b1;
        #1;
        check("async_reset_leds", {31'd0, leds_on}, 32'd0);
        check("async_reset_winrnd", {31'd0, winrnd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_level(1'b1, 100, n);
        check("arm_after_mid_reset", n, ARM_TO_LIGHT);

        repeat (2) @(negedge clk);
        check("results_all_seen", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
